cash_dispenser: RTL and testbench
=================================

Name: cash_dispenser

Overview:
- Downstream of the ATM transaction FSM. Receives an approved withdraw amount once the transaction reaches its confirm point.
- Plans a greedy note breakdown against the cassette inventory, then releases notes one at a time to the dispense mechanism through a valid/taken handshake.
- Reports a result code back to the FSM.
- Owns the four cassette counters and the total-cash figure the FSM compares withdraw amounts against.

Parameters:
- AMT_W, 32, width of amounts and total_cash
- CNT_W, 10, width of each cassette note counter
- D0, 200, denomination of cassette 0 (highest)
- D1, 100, denomination of cassette 1
- D2, 50, denomination of cassette 2
- D3, 10, denomination of cassette 3 (lowest). Also the amount granularity.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  withdraw request present
- req_ready  out  1  block can accept a request
- req_amount  in  AMT_W  requested amount in currency units
- resp_valid  out  1  one-cycle result pulse
- resp_code  out  2  00 OK, 01 BAD_AMOUNT, 10 NO_FUNDS, 11 NO_CHANGE
- note_valid  out  1  a note is presented to the mechanism
- note_sel  out  2  cassette index of the presented note
- note_taken  in  1  mechanism accepted the presented note
- load_en  in  1  cassette reload strobe
- load_sel  in  2  cassette to reload
- load_count  in  CNT_W  new note count, replaces the old value
- total_cash  out  AMT_W  registered sum of cnt_i*D_i

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - All cassette counts, plan counts, remainder and total_cash go to 0.
  - req_ready=0, resp_valid=0, resp_code=00, note_valid=0, note_sel=0.
  - Reset during DISPENSE abandons the transaction. No resp is issued.
- States: IDLE, CHECK, PLAN, DISPENSE, DONE.
- IDLE:
  - req_ready=1 only in IDLE.
  - load_en in IDLE writes cnt[load_sel]=load_count. load_en outside IDLE is ignored.
  - If load_en and req_valid are both high in the same cycle, the load wins and req_ready is 0 that cycle.
  - Accept on req_valid&&req_ready: latch amount into rem, then go to CHECK.
- CHECK (1 cycle):
  - rem==0 or rem%D3!=0 → code 01, go to DONE.
  - rem>total_cash → code 10, go to DONE.
  - Otherwise go to PLAN.
- PLAN (4 cycles, i=0..3, one denomination per cycle):
  - plan_i = min(rem/D_i, cnt_i).
  - rem -= plan_i*D_i.
  - Division is by a constant. Intermediate products are AMT_W wide and cannot overflow because plan_i*D_i ≤ rem.
  - After i=3: rem!=0 → code 11, go to DONE, inventory unchanged. Otherwise go to DISPENSE.
- DISPENSE:
  - note_valid=1. note_sel = lowest index i with plan_i>0 (highest denomination first).
  - On note_taken: plan_i-=1 and cnt_i-=1. The next note is presented the following cycle.
  - note_valid stays high continuously while notes remain. There is no gap cycle between notes.
  - When the last note is taken, go to DONE with code 00.
  - note_taken while note_valid=0 is ignored.
- DONE (1 cycle): resp_valid=1 with resp_code, then return to IDLE.
- Latency:
  - Request accepted at cycle T: error from CHECK gives resp at T+2; NO_CHANGE gives resp at T+6.
  - A successful request gives resp one cycle after the final note_taken.
- total_cash:
  - Recomputed and registered every cycle from the cnt values, so it lags a load or decrement by 1 cycle.
  - The CHECK state compares against this registered value.
- Cassette counters never underflow. A plan never exceeds cnt_i.

Decomposition:
- Package atm_pkg:
  - denomination constants D0–D3
  - resp_code enum (OK, BAD_AMOUNT, NO_FUNDS, NO_CHANGE)
  - dispenser state enum
  - note_sel width constant
- Sub-module cassette_bank holds:
  - the four cnt registers, the load port and the single-note decrement port
  - the registered total_cash computation
- cash_dispenser holds the FSM, the plan registers and the remainder.

Test Plan:
- Load counts 5,5,5,5 (total_cash=1800), request 380 → notes in order 0,1,2,3,3,3 (6 notes), resp 00, counts 4,4,4,2, total_cash 1420.
- Request 0 → resp 01 at T+2, no note_valid. Request 35 → resp 01 at T+2.
- Counts 5,5,5,5, request 5000 → resp 10 at T+2, inventory unchanged.
- Load counts 0,0,1,0 (total 50), request 40 → resp 11 at T+6, cnt2 still 1, no note_valid.
- Request 380 with note_taken held low for 3 cycles on the first note → note_valid/note_sel=0 held stable. A load_en pulse during DISPENSE does not change cnt.
- Request 380, assert reset after 2 notes taken → note_valid=0, req_ready=0 during reset, all counts 0, no resp. After release: IDLE, req_ready=1.

Source files
------------

// File: rtl/atm_pkg.sv
// atm_pkg
//   Shared constants and types for the ATM cash dispenser slice.
//   - D0..D3 : note denominations, highest first. D3 is also the amount granularity.
//   - SEL_W  : width of a cassette index.
//   - resp_code_t : result code returned to the transaction FSM.
//   - ST_* : dispenser FSM state encodings.
package atm_pkg;

  localparam int D0 = 200;
  localparam int D1 = 100;
  localparam int D2 = 50;
  localparam int D3 = 10;

  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    RESP_OK         = 2'b00,
    RESP_BAD_AMOUNT = 2'b01,
    RESP_NO_FUNDS   = 2'b10,
    RESP_NO_CHANGE  = 2'b11
  } resp_code_t;

  // Plain constants rather than an enum so the encoding stays visible to older tools.
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CHECK    = 3'd1;
  localparam logic [2:0] ST_PLAN     = 3'd2;
  localparam logic [2:0] ST_DISPENSE = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

endpackage

// File: rtl/cash_dispenser_if.sv
// cash_dispenser_if
//   Bundles the request/response handshake, the note handshake, the cassette
//   reload port and the total_cash figure.
//   - master : the transaction FSM / mechanism side (drives requests, note_taken, loads)
//   - slave  : the dispenser itself
interface cash_dispenser_if #(
  parameter int AMT_W = 32,
  parameter int CNT_W = 10
) ();

  logic                        req_valid;
  logic                        req_ready;
  logic [AMT_W-1:0]            req_amount;
  logic                        resp_valid;
  logic [1:0]                  resp_code;
  logic                        note_valid;
  logic [atm_pkg::SEL_W-1:0]   note_sel;
  logic                        note_taken;
  logic                        load_en;
  logic [1:0]                  load_sel;
  logic [CNT_W-1:0]            load_count;
  logic [AMT_W-1:0]            total_cash;

  modport master (
    output req_valid, req_amount, note_taken, load_en, load_sel, load_count,
    input  req_ready, resp_valid, resp_code, note_valid, note_sel, total_cash
  );

  modport slave (
    input  req_valid, req_amount, note_taken, load_en, load_sel, load_count,
    output req_ready, resp_valid, resp_code, note_valid, note_sel, total_cash
  );

endinterface

// File: rtl/cassette_bank.sv
// cassette_bank
//   Holds the four cassette note counters and the registered total_cash.
//   Ports:
//   - clk, reset      : clock, asynchronous active-low reset
//   - load_en/sel/count : overwrite one counter (caller gates this to IDLE)
//   - dec_en, dec_sel : remove one note from a cassette
//   - cnt             : current counter values
//   - total_cash      : sum of cnt[i]*D[i], one cycle behind the counters
module cassette_bank
  import atm_pkg::*;
#(
  parameter int AMT_W = 32,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [1:0]       load_sel,
  input  logic [CNT_W-1:0] load_count,
  input  logic             dec_en,
  input  logic [1:0]       dec_sel,
  output logic [CNT_W-1:0] cnt [4],
  output logic [AMT_W-1:0] total_cash
);

  // Load and decrement never coincide (load only in IDLE, decrement only in
  // DISPENSE); the zero guard keeps a counter from ever wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '{default: '0};
    end else if (load_en) begin
      cnt[load_sel] <= load_count;
    end else if (dec_en && cnt[dec_sel] != '0) begin
      cnt[dec_sel] <= cnt[dec_sel] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_cash <= '0;
    end else begin
      total_cash <= AMT_W'(cnt[0]) * AMT_W'(D0) + AMT_W'(cnt[1]) * AMT_W'(D1)
                  + AMT_W'(cnt[2]) * AMT_W'(D2) + AMT_W'(cnt[3]) * AMT_W'(D3);
    end
  end

endmodule

// File: rtl/cash_dispenser.sv
// cash_dispenser
//   Accepts an approved withdraw amount, validates it, plans a greedy note
//   breakdown against the cassette inventory and releases the notes one at a
//   time, then reports a result code.
//   Ports:
//   - clk   : rising-edge clock
//   - reset : asynchronous active-low reset
//   - bus   : cash_dispenser_if slave (request, response, notes, reload, total_cash)
module cash_dispenser
  import atm_pkg::*;
#(
  parameter int AMT_W = 32,
  parameter int CNT_W = 10
) (
  input  logic       clk,
  input  logic       reset,
  cash_dispenser_if.slave bus
);

  logic [2:0]       state;
  logic [AMT_W-1:0] rem;
  logic [CNT_W-1:0] plan [4];
  logic [1:0]       plan_idx;
  logic [1:0]       code;

  logic [CNT_W-1:0] cnt [4];
  logic [AMT_W-1:0] quot, denom, cnt_ext, take, rem_next;
  logic [1:0]       sel;
  logic             others_left, last_note;
  logic             bank_load, bank_dec;

  assign bank_load = bus.load_en && (state == ST_IDLE);
  assign bank_dec  = bus.note_taken && (state == ST_DISPENSE);

  cassette_bank #(.AMT_W(AMT_W), .CNT_W(CNT_W)) bank (
    .clk        (clk),
    .reset      (reset),
    .load_en    (bank_load),
    .load_sel   (bus.load_sel),
    .load_count (bus.load_count),
    .dec_en     (bank_dec),
    .dec_sel    (sel),
    .cnt        (cnt),
    .total_cash (bus.total_cash)
  );

  // One greedy step: each branch divides by a fixed denomination so every
  // divider is a constant divider.
  always_comb begin
    denom = AMT_W'(D3);
    quot  = '0;
    case (plan_idx)
      2'd0: begin denom = AMT_W'(D0); quot = rem / AMT_W'(D0); end
      2'd1: begin denom = AMT_W'(D1); quot = rem / AMT_W'(D1); end
      2'd2: begin denom = AMT_W'(D2); quot = rem / AMT_W'(D2); end
      default: begin denom = AMT_W'(D3); quot = rem / AMT_W'(D3); end
    endcase
    cnt_ext  = AMT_W'(cnt[plan_idx]);
    take     = (quot < cnt_ext) ? quot : cnt_ext;
    rem_next = rem - take * denom;
  end

  // Lowest cassette index with notes still planned, i.e. highest denomination first.
  always_comb begin
    sel = 2'd0;
    if (plan[3] != '0) sel = 2'd3;
    if (plan[2] != '0) sel = 2'd2;
    if (plan[1] != '0) sel = 2'd1;
    if (plan[0] != '0) sel = 2'd0;
  end

  // The presented note is the last one when it is the only note left in the plan.
  always_comb begin
    others_left = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i != int'(sel) && plan[i] != '0) others_left = 1'b1;
    end
    last_note = !others_left && (plan[sel] == CNT_W'(1));
  end

  // A same-cycle reload takes priority over a request, and nothing is accepted during reset.
  assign bus.req_ready  = reset && (state == ST_IDLE) && !bus.load_en;
  assign bus.resp_valid = (state == ST_DONE);
  assign bus.resp_code  = code;
  assign bus.note_valid = (state == ST_DISPENSE);
  assign bus.note_sel   = (state == ST_DISPENSE) ? sel : 2'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      rem      <= '0;
      plan     <= '{default: '0};
      plan_idx <= 2'd0;
      code     <= RESP_OK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            rem   <= bus.req_amount;
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          plan_idx <= 2'd0;
          if (rem == '0 || (rem % AMT_W'(D3)) != '0) begin
            code  <= RESP_BAD_AMOUNT;
            state <= ST_DONE;
          end else if (rem > bus.total_cash) begin
            code  <= RESP_NO_FUNDS;
            state <= ST_DONE;
          end else begin
            state <= ST_PLAN;
          end
        end
        ST_PLAN: begin
          plan[plan_idx] <= CNT_W'(take);
          rem            <= rem_next;
          plan_idx       <= plan_idx + 2'd1;
          if (plan_idx == 2'd3) begin
            if (rem_next != '0) begin
              code  <= RESP_NO_CHANGE;
              state <= ST_DONE;
            end else begin
              state <= ST_DISPENSE;
            end
          end
        end
        ST_DISPENSE: begin
          if (bus.note_taken) begin
            plan[sel] <= plan[sel] - CNT_W'(1);
            if (last_note) begin
              code  <= RESP_OK;
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cash_dispenser.sv
// tb_cash_dispenser
//   Self-checking bench for cash_dispenser: a table of requests with
//   hand-derived result codes, latencies and resulting total_cash, a greedy
//   note model that feeds a scoreboard queue of expected note indices, and
//   hand-written sequences for stalls, load/request collisions and reset
//   mid-dispense.
module tb_cash_dispenser;
  import atm_pkg::*;

  localparam int AMT_W = 32;
  localparam int CNT_W = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  cash_dispenser_if #(.AMT_W(AMT_W), .CNT_W(CNT_W)) dif ();

  cash_dispenser #(.AMT_W(AMT_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  typedef struct {
    bit         do_load;
    int         c0, c1, c2, c3;
    int         amount;
    logic [1:0] code;
    int         lat;
    int         total;
  } vec_t;

  vec_t vecs [10];

  int n_vec  = 0;
  int n_miss = 0;
  int model_cnt [4];
  logic [1:0] exp_notes [$];
  logic [1:0] exp_resp  [$];

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int denom_of(input int i);
    case (i)
      0: return D0;
      1: return D1;
      2: return D2;
      default: return D3;
    endcase
  endfunction

  function automatic int model_total();
    int t = 0;
    for (int i = 0; i < 4; i++) t += model_cnt[i] * denom_of(i);
    return t;
  endfunction

  // Greedy reference: pushes the expected note sequence and debits the model
  // inventory only when the amount is valid, affordable and exactly payable.
  task automatic predict_notes(input int amt);
    int r;
    int p [4];
    if (amt == 0 || amt % D3 != 0 || amt > model_total()) return;
    r = amt;
    for (int i = 0; i < 4; i++) begin
      p[i] = r / denom_of(i);
      if (p[i] > model_cnt[i]) p[i] = model_cnt[i];
      r -= p[i] * denom_of(i);
    end
    if (r != 0) return;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < p[i]; j++) exp_notes.push_back(2'(i));
      model_cnt[i] -= p[i];
    end
  endtask

  task automatic load_cassette(input int sel, input int count);
    dif.load_en    = 1'b1;
    dif.load_sel   = 2'(sel);
    dif.load_count = CNT_W'(count);
    @(negedge clk);
    dif.load_en    = 1'b0;
    model_cnt[sel] = count;
  endtask

  task automatic load_all(input int c0, input int c1, input int c2, input int c3);
    load_cassette(0, c0);
    load_cassette(1, c1);
    load_cassette(2, c2);
    load_cassette(3, c3);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic reset_midway();
    dif.note_taken = 1'b0;
    reset = 1'b0;
    #1;
    check_output("reset_note_valid", dif.note_valid, 0);
    check_output("reset_req_ready", dif.req_ready, 0);
    check_output("reset_total_cash", dif.total_cash, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_output("reset_no_resp", dif.resp_valid, 0);
    end
    exp_notes.delete();
    exp_resp.delete();
    for (int i = 0; i < 4; i++) model_cnt[i] = 0;
    reset = 1'b1;
    #1;
    check_output("post_reset_req_ready", dif.req_ready, 1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_output("post_reset_no_resp", dif.resp_valid, 0);
    end
  endtask

  // Drives one request from a negedge and services the note handshake.
  // exp_lat>0 checks error latency from the accept cycle; otherwise the
  // response must come one cycle after the final note is taken.
  task automatic apply_stimulus(input int amt, input int exp_lat, input int hold_cycles,
                                input bit pulse_load, input int abort_after);
    int taken = 0;
    int last_take = -1;
    int held = 0;
    bit got = 1'b0;
    check_output("req_ready_idle", dif.req_ready, 1);
    dif.req_amount = AMT_W'(amt);
    dif.req_valid  = 1'b1;
    @(negedge clk);
    dif.req_valid  = 1'b0;
    for (int k = 1; k <= 80 && !got; k++) begin
      dif.note_taken = 1'b0;
      dif.load_en    = 1'b0;
      if (abort_after > 0 && taken == abort_after) begin
        reset_midway();
        return;
      end
      if (dif.resp_valid) begin
        got = 1'b1;
        if (exp_resp.size() == 0) check_output("resp_unexpected", dif.resp_valid, 0);
        else check_output("resp_code", dif.resp_code, exp_resp.pop_front());
        if (exp_lat > 0) check_output("resp_latency", k, exp_lat);
        else check_output("resp_after_last_note", k, last_take + 1);
        check_output("notes_outstanding", exp_notes.size(), 0);
      end else if (dif.note_valid) begin
        if (exp_notes.size() == 0) begin
          check_output("note_valid_unexpected", dif.note_valid, 0);
        end else if (held < hold_cycles) begin
          check_output("note_sel_stalled", dif.note_sel, exp_notes[0]);
          held++;
          if (pulse_load && held == 1) begin
            dif.load_en    = 1'b1;
            dif.load_sel   = 2'd0;
            dif.load_count = '0;
          end
        end else begin
          check_output("note_sel", dif.note_sel, exp_notes.pop_front());
          dif.note_taken = 1'b1;
          taken++;
          last_take = k;
        end
      end
      @(negedge clk);
    end
    dif.note_taken = 1'b0;
    dif.load_en    = 1'b0;
    if (!got) begin
      n_vec++;
      n_miss++;
      $display("[TB] FAIL resp_timeout: got no resp, expected resp within 80 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    dif.req_valid  = 1'b0;
    dif.req_amount = '0;
    dif.note_taken = 1'b0;
    dif.load_en    = 1'b0;
    dif.load_sel   = 2'd0;
    dif.load_count = '0;
    for (int i = 0; i < 4; i++) model_cnt[i] = 0;

    //          load  c0 c1 c2 c3  amount  code             lat total
    vecs[0] = '{1'b1, 5, 5, 5, 5,   380, RESP_OK,         0, 1420};
    vecs[1] = '{1'b0, 0, 0, 0, 0,     0, RESP_BAD_AMOUNT, 2, 1420};
    vecs[2] = '{1'b0, 0, 0, 0, 0,    35, RESP_BAD_AMOUNT, 2, 1420};
    vecs[3] = '{1'b0, 0, 0, 0, 0,  5000, RESP_NO_FUNDS,   2, 1420};
    vecs[4] = '{1'b0, 0, 0, 0, 0,  1430, RESP_NO_FUNDS,   2, 1420};
    vecs[5] = '{1'b0, 0, 0, 0, 0,  1420, RESP_OK,         0,    0};
    vecs[6] = '{1'b0, 0, 0, 0, 0,    10, RESP_NO_FUNDS,   2,    0};
    vecs[7] = '{1'b1, 0, 0, 1, 0,    40, RESP_NO_CHANGE,  6,   50};
    vecs[8] = '{1'b0, 0, 0, 0, 0,    50, RESP_OK,         0,    0};
    vecs[9] = '{1'b1, 3, 0, 0,10,   300, RESP_OK,         0,  400};

    // Reset state.
    repeat (3) @(negedge clk);
    check_output("rst_req_ready", dif.req_ready, 0);
    check_output("rst_resp_valid", dif.resp_valid, 0);
    check_output("rst_resp_code", dif.resp_code, 0);
    check_output("rst_note_valid", dif.note_valid, 0);
    check_output("rst_note_sel", dif.note_sel, 0);
    check_output("rst_total_cash", dif.total_cash, 0);
    reset = 1'b1;
    #1;
    check_output("idle_req_ready", dif.req_ready, 1);
    @(negedge clk);

    // Table-driven requests.
    for (int v = 0; v < 10; v++) begin
      if (vecs[v].do_load) begin
        load_all(vecs[v].c0, vecs[v].c1, vecs[v].c2, vecs[v].c3);
        if (v == 0) check_output("loaded_total_cash", dif.total_cash, 1800);
      end
      predict_notes(vecs[v].amount);
      exp_resp.push_back(vecs[v].code);
      apply_stimulus(vecs[v].amount, vecs[v].lat, 0, 1'b0, 0);
      @(negedge clk);
      check_output($sformatf("total_cash_v%0d", v), dif.total_cash, vecs[v].total);
    end

    // Load and request in the same cycle: the load wins, the request waits.
    dif.load_en    = 1'b1;
    dif.load_sel   = 2'd1;
    dif.load_count = CNT_W'(2);
    dif.req_valid  = 1'b1;
    dif.req_amount = AMT_W'(100);
    #1;
    check_output("collision_req_ready", dif.req_ready, 0);
    @(negedge clk);
    dif.load_en   = 1'b0;
    dif.req_valid = 1'b0;
    model_cnt[1]  = 2;
    for (int c = 0; c < 3; c++) begin
      check_output("collision_no_resp", dif.resp_valid, 0);
      @(negedge clk);
    end
    check_output("collision_total_cash", dif.total_cash, 600);

    // Stalled first note plus an ignored reload during DISPENSE.
    load_all(5, 5, 5, 5);
    predict_notes(380);
    exp_resp.push_back(RESP_OK);
    apply_stimulus(380, 0, 3, 1'b1, 0);
    @(negedge clk);
    check_output("stall_total_cash", dif.total_cash, 1420);

    // Reset after two notes abandons the transaction.
    load_all(5, 5, 5, 5);
    predict_notes(380);
    exp_resp.push_back(RESP_OK);
    apply_stimulus(380, 0, 0, 1'b0, 2);
    check_output("after_abort_total_cash", dif.total_cash, 0);

    // Inventory is empty after the reset, so any valid amount lacks funds.
    exp_resp.push_back(RESP_NO_FUNDS);
    apply_stimulus(10, 2, 0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
